muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative sequencer for the RV32M multiply/divide group, sitting beside the ALU in the EX stage. It accepts one M-extension operation at a time, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and applies sign fixups. It holds `busy` to stall the pipeline until it produces a one-cycle `done` pulse with the result. Special divide cases finish in one cycle.

## Interface
- `WIDTH`, 32, operand/result width (even, ≥ 4)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low (reset when 0)
- `start`  in  1  request; an M-op is in EX (R-type, Funct7 = 0000001)
- `flush`  in  1  kill the in-flight operation (branch/jump flush)
- `Funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `SrcA`  in  WIDTH  rs1 operand (dividend / multiplicand)
- `SrcB`  in  WIDTH  rs2 operand (divisor / multiplier)
- `busy`  out  1  pipeline stall request
- `done`  out  1  one-cycle pulse; `Result` valid
- `Result`  out  WIDTH  product/quotient/remainder; held until the next completion

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- **Start accepted:** `start`=1 in IDLE with `flush`=0 accepts a request.
  - Latch `Funct3`.
  - Latch magnitudes |SrcA| and |SrcB|, taking the absolute value only for signed operands: MULH both; MULHSU SrcA only; DIV/REM both.
  - Latch the result-sign flag: for MUL* it is the XOR of the operand signs; for DIV it is the quotient sign; for REM it is the dividend sign.
  - Clear the iteration counter and go to CALC.
- **Special cases** (evaluated at acceptance; go straight to DONE):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give SrcA.
  - Signed overflow (SrcA = 1 followed by zeros, SrcB = all ones), DIV/REM only: DIV gives SrcA, REM gives 0.
- **CALC:** one iteration per cycle, counter 0..WIDTH-1; after the iteration with counter = WIDTH-1, go to FIXUP.
  - MUL: 2·WIDTH product register. If the multiplier LSB is 1, add the multiplicand to the upper half, then shift right 1, keeping the carry.
  - DIV: restoring. Shift {rem, quo} left 1, trial-subtract the divisor from rem; if non-negative, keep the difference and set quo LSB to 1.
- **FIXUP:** negate the chosen value if the sign flag is set.
  - MUL takes product[WIDTH-1:0].
  - MULH/MULHSU/MULHU take product[2·WIDTH-1:WIDTH], negating the full 2·WIDTH product before selecting the half.
  - DIV* take the quotient; REM* take the remainder.
  - Load `Result`, go to DONE.
- **DONE:** `done`=1, return to IDLE next cycle.
- `busy` = (IDLE & `start` & ~`flush`) | CALC | FIXUP. It is combinational so the requesting instruction stalls in its first cycle. It is 0 in DONE so the instruction retires.
- `start` outside IDLE is ignored. `start` in DONE is not accepted until IDLE.
- **Flush:** `flush`=1 in any state sends the FSM to IDLE next cycle. No `done` is produced and `Result` is unchanged. `flush` takes priority over `start`.
- **Reset** (`reset`=0, mid-operation included): state IDLE, counter 0, `Result` 0, `done` 0, `busy` 0. `busy` is forced 0 while `reset`=0.

## Timing
- `start` sampled at edge 0.
- Normal ops:
  - CALC occupies cycles 1..WIDTH.
  - FIXUP is cycle WIDTH+1.
  - DONE (`done`=1, `Result` valid) is cycle WIDTH+2, i.e. 34 for WIDTH = 32.
- Special cases: DONE in cycle 1.
- `busy` is high from cycle 0 through cycle WIDTH+1 inclusive (cycle 0 only for special cases).
- Back-to-back: the next `start` is accepted at the earliest in cycle WIDTH+3.
- `Result` changes only at the edge entering DONE.

## Structure
- Shared package `muldiv_pkg` holds:
  - `muldiv_op_e` enum of the eight Funct3 encodings;
  - `muldiv_state_e` (IDLE, CALC, FIXUP, DONE);
  - `MULDIV_FUNCT7` = 7'b0000001;
  - helper functions `is_signed_a`, `is_signed_b`, `is_div`.
- Single module with no sub-module; the FSM and the shared add/sub datapath are in one file. Counter width is $clog2(WIDTH)+1.

## Test plan
- MUL 7 × 0xFFFFFFFD, start at cycle 0 → `Result` 0xFFFFFFEB, `done` only in cycle 34, `busy` high in cycles 0–33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU with the same operands → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 0x12345678 / 0 → 0xFFFFFFFF, `done` in cycle 1. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with `done` in cycle 1. REM with the same operands → 0.
- Flush and reset mid-operation:
  - Start MUL, raise `flush` in cycle 10 → `busy` 0 from cycle 11, no `done`, prior `Result` held. A new DIVU starting in cycle 12 completes at cycle 46.
  - Drive `reset`=0 in cycle 20 of a DIV → `Result` 0, `busy`/`done` 0 next cycle. A `start` during reset is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } muldiv_state_e;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide unit for the RV32M group.
// Operates on magnitudes and applies the sign in a single fixup cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e state, state_next;
    muldiv_op_e    op, req_op;
    logic                 sign;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   prod, prod_next, neg_prod;
    logic [WIDTH-1:0]     operand;
    logic [WIDTH-1:0]     mag_a, mag_b, special_val, fix_val, neg_lo, neg_hi;
    logic                 a_neg, b_neg, div_zero, div_ovf, special, accept, op_div;
    logic [WIDTH:0]       add_a, add_b, sum;

    assign req_op   = muldiv_op_e'(Funct3);
    assign a_neg    = is_signed_a(req_op) && SrcA[WIDTH-1];
    assign b_neg    = is_signed_b(req_op) && SrcB[WIDTH-1];
    assign mag_a    = a_neg ? -SrcA : SrcA;
    assign mag_b    = b_neg ? -SrcB : SrcB;
    assign div_zero = is_div(req_op) && (SrcB == '0);
    assign div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) && (SrcA == INT_MIN) && (SrcB == '1);
    assign special  = div_zero || div_ovf;
    assign accept   = (state == IDLE) && start && !flush;

    // Divide-by-zero and signed overflow have fixed architectural results.
    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = Funct3[1] ? SrcA : '1;
        else
            special_val = Funct3[1] ? '0 : SrcA;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (cnt == LAST) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // One adder serves both: multiplicand add into the upper half, or trial
    // subtract of the divisor from the shifted-in partial remainder.
    assign op_div = is_div(op);
    assign add_a  = op_div ? {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} : {1'b0, prod[2*WIDTH-1:WIDTH]};
    assign add_b  = op_div ? ~{1'b0, operand} : {1'b0, operand};
    assign sum    = add_a + add_b + {{WIDTH{1'b0}}, op_div};

    always_comb begin
        prod_next = prod;
        if (op_div) begin
            if (!sum[WIDTH])
                prod_next = {sum[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
            else
                prod_next = {add_a[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end else if (prod[0]) begin
            prod_next = {sum, prod[WIDTH-1:1]};
        end else begin
            prod_next = {1'b0, prod[2*WIDTH-1:1]};
        end
    end

    assign neg_prod = -prod;
    assign neg_lo   = -prod[WIDTH-1:0];
    assign neg_hi   = -prod[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_val = '0;
        case (op)
            OP_MUL:                        fix_val = sign ? neg_prod[WIDTH-1:0] : prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = sign ? neg_prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_val = sign ? neg_lo : prod[WIDTH-1:0];
            OP_REM, OP_REMU:               fix_val = sign ? neg_hi : prod[2*WIDTH-1:WIDTH];
            default:                       fix_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            op      <= OP_MUL;
            sign    <= 1'b0;
            cnt     <= '0;
            prod    <= '0;
            operand <= '0;
            Result  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    op   <= req_op;
                    sign <= (is_div(req_op) && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt  <= '0;
                    if (is_div(req_op)) begin
                        prod    <= {{WIDTH{1'b0}}, mag_a};
                        operand <= mag_b;
                    end else begin
                        prod    <= {{WIDTH{1'b0}}, mag_b};
                        operand <= mag_a;
                    end
                    if (special)
                        Result <= special_val;
                end
                CALC: begin
                    prod <= prod_next;
                    cnt  <= cnt + CW'(1);
                end
                FIXUP: if (!flush) Result <= fix_val;
                default: ;
            endcase
        end
    end

    assign busy = reset && (accept || (state == CALC) || (state == FIXUP));
    assign done = reset && (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed RV32M cases plus randomized traffic against a
// cycle-level arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic          flush;
    logic [2:0]    Funct3;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          busy;
    logic          done;
    logic [W-1:0]  Result;

    int n_vectors = 0;
    int n_miscompares = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s t=%0t got=0x%08h expected=0x%08h", name, $time, actual, expected);
        end
    endtask

    // Architectural result of one M-extension instruction.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Reference model: an accepted op completes a fixed number of cycles later.
    int          cyc = 0;
    int          done_at = 0;
    logic        active = 1'b0;
    logic        checking = 1'b0;
    logic [31:0] pend = '0;
    logic [31:0] held = '0;

    always @(posedge clk) begin
        if (!reset) begin
            active   = 1'b0;
            held     = '0;
            checking = 1'b1;
        end else if (flush) begin
            active = 1'b0;
        end else if (!active) begin
            if (start) begin
                active = 1'b1;
                pend   = ref_result(Funct3, SrcA, SrcB);
                if (ref_special(Funct3, SrcA, SrcB)) begin
                    done_at = cyc + 1;
                    held    = pend;
                end else begin
                    done_at = cyc + W + 2;
                end
            end
        end else if (cyc == done_at - 1) begin
            held = pend;
        end else if (cyc == done_at) begin
            active = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy", {31'b0, busy},
                {31'b0, reset && ((!active && start && !flush) || (active && cyc < done_at))});
            checkOutput("done", {31'b0, done}, {31'b0, reset && active && cyc == done_at});
            checkOutput("Result", Result, held);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (active && n < 60) begin
            tick();
            n++;
        end
        if (active) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic run_directed(input string name, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        wait_idle();
        applyStimulus(f, a, b);
        wait_done(n);
        checkOutput({name, "_result"}, Result, exp_res);
        checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
        tick();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    int          n;
    logic [31:0] ra, rb;

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        run_directed("mul",       3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_directed("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_directed("mulh",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_directed("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_directed("div",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_directed("rem",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_directed("divu",      3'd5, 32'd100,       32'd7,         32'd14,        34);
        run_directed("remu",      3'd7, 32'd100,       32'd7,         32'd2,         34);
        run_directed("divu_by0",  3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_directed("rem_by0",   3'd6, 32'd5,         32'd0,         32'd5,         1);
        run_directed("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_directed("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // Flush a multiply in its cycle 10, then restart with a DIVU in cycle 12.
        wait_idle();
        applyStimulus(3'd0, 32'd3, 32'd5);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        checkOutput("flush_held", Result, 32'h0);
        tick();
        applyStimulus(3'd5, 32'd1000, 32'd10);
        wait_done(n);
        checkOutput("flush_restart_cycle", 32'(n + 12), 32'd46);
        checkOutput("flush_restart_result", Result, 32'd100);
        tick();

        // Reset in cycle 20 of a DIV, with a special-case start held during reset.
        wait_idle();
        applyStimulus(3'd4, 32'd1000, 32'd7);
        repeat (19) tick();
        reset  = 1'b0;
        start  = 1'b1;
        Funct3 = 3'd5;
        SrcB   = 32'd0;
        tick();
        checkOutput("reset_result", Result, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        checkOutput("post_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("post_reset_done", {31'b0, done}, 32'd0);
        checkOutput("post_reset_result", Result, 32'h0);

        // Random traffic with stray starts, flushes and the odd reset.
        for (int i = 0; i < 150; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            flush = ($urandom_range(0, 9) == 0);
            applyStimulus(3'($urandom_range(0, 7)), ra, rb);
            flush = 1'b0;
            n = 0;
            while (active && n < 60) begin
                start  = ($urandom_range(0, 3) == 0);
                Funct3 = 3'($urandom_range(0, 7));
                SrcA   = pick_operand();
                SrcB   = pick_operand();
                flush  = ($urandom_range(0, 49) == 0);
                reset  = ($urandom_range(0, 199) != 0);
                tick();
                n++;
            end
            start = 1'b0;
            flush = 1'b0;
            reset = 1'b1;
            if (active) checkOutput("random_timeout", 32'd1, 32'd0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
